// File: rtl/fu_op_issuer.sv
// fu_op_issuer
// Sequential front end for the 8-bit functional unit. It accepts an opcode
// and operand-pair command, decodes the opcode into the unit's one-hot
// instruction word and 3-bit select code, and holds both stable for
// SETTLE_CYCLES cycles. It then captures the unit's F output and returns it
// over a valid/ready handshake.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  command handshake (op, pair)
//   op[2:0]            opcode 0..7: add, add-not, and, or, max, min,
//                      rotr-add, rotl-add
//   pair[1:0]          operand pair 0=(A,B) 1=(A,C) 2=(B,C) 3=(C,A)
//   instruction[7:0]   one-hot opcode to the functional unit
//   select[2:0]        operand select to the functional unit
//   F[7:0]             functional unit output
//   result[7:0]        captured F
//   result_valid/result_ready  result handshake
//   op_count[7:0]      completed operations, modulo 256
//
// state | meaning
// IDLE  | ready for a command; unit inputs driven to zero
// ISSUE | decoded instruction/select held while the unit settles
// RESP  | result presented; waiting for the consumer to accept it

module fu_op_issuer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [1:0] pair,
    output logic [7:0] instruction,
    output logic [2:0] select,
    input  logic [7:0] F,
    output logic [7:0] result,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] pair_q, pair_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic [7:0] count_q, count_d;

    logic [7:0] instr_dec;
    logic [2:0] sel_dec;

    // Decode only from the latched command so late input changes are ignored.
    always_comb begin
        instr_dec = 8'd1 << op_q;
        unique case (pair_q)
            2'd0:    sel_dec = 3'b110;
            2'd1:    sel_dec = 3'b101;
            2'd2:    sel_dec = 3'b011;
            default: sel_dec = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            pair_q   <= 2'd0;
            cnt_q    <= 4'd0;
            result_q <= 8'd0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pair_q   <= pair_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pair_d       = pair_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        count_d      = count_q;
        in_ready     = 1'b0;
        instruction  = 8'h00;
        select       = 3'b000;
        result_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d    = op;
                    pair_d  = pair;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                instruction = instr_dec;
                select      = sel_dec;
                if (cnt_q == 4'd0) begin
                    result_d = F;
                    count_d  = count_q + 8'd1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result   = result_q;
    assign op_count = count_q;

endmodule

// File: tb/tb_fu_op_issuer.sv
module tb_fu_op_issuer;

    localparam logic [7:0] VAL_A = 8'h0F;
    localparam logic [7:0] VAL_B = 8'h03;
    localparam logic [7:0] VAL_C = 8'hF0;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [1:0] pair;
    logic [7:0] instruction;
    logic [2:0] select;
    logic [7:0] F;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] op_count;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_cnt;
    logic [7:0] held;

    fu_op_issuer #(.SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .pair        (pair),
        .instruction (instruction),
        .select      (select),
        .F           (F),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // Reference functional unit driven from the DUT's instruction/select.
    // Anything not a legal one-hot/select pattern yields 8'hEE.
    logic [7:0] fx, fy;
    logic       sel_ok;
    always_comb begin
        fx     = 8'h00;
        fy     = 8'h00;
        sel_ok = 1'b1;
        case (select)
            3'b110:  begin fx = VAL_A; fy = VAL_B; end
            3'b101:  begin fx = VAL_A; fy = VAL_C; end
            3'b011:  begin fx = VAL_B; fy = VAL_C; end
            3'b000:  begin fx = VAL_C; fy = VAL_A; end
            default: sel_ok = 1'b0;
        endcase
        F = 8'hEE;
        if (sel_ok) begin
            case (instruction)
                8'h01: F = fx + fy;
                8'h02: F = fx + ~fy;
                8'h04: F = fx & fy;
                8'h08: F = fx | fy;
                8'h10: F = (fx > fy) ? fx : fy;
                8'h20: F = (fx < fy) ? fx : fy;
                8'h40: F = {fx[0], fx[7:1]} + fy;
                8'h80: F = {fx[6:0], fx[7]} + fy;
                default: F = 8'hEE;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_instr"}, 32'(instruction), 32'h00);
        chk({tag, "_select"}, 32'(select), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'h00);
        chk({tag, "_rvalid"}, 32'(result_valid), 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    // Full directed command with per-cycle checks (SETTLE_CYCLES = 2).
    task automatic run_cmd(input logic [2:0] c_op, input logic [1:0] c_pair,
                           input logic [7:0] e_instr, input logic [2:0] e_sel,
                           input logic [7:0] e_res);
        chk("acc_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op       = c_op;
        pair     = c_pair;
        tick();
        in_valid = 1'b0;
        op       = ~c_op;
        pair     = ~c_pair;
        for (int i = 0; i < 2; i++) begin
            chk("iss_instr", 32'(instruction), 32'(e_instr));
            chk("iss_select", 32'(select), 32'(e_sel));
            chk("iss_in_ready", 32'(in_ready), 32'd0);
            chk("iss_rvalid", 32'(result_valid), 32'd0);
            tick();
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("resp_rvalid", 32'(result_valid), 32'd1);
        chk("resp_result", 32'(result), 32'(e_res));
        chk("resp_op_count", 32'(op_count), 32'(exp_cnt));
        chk("resp_instr", 32'(instruction), 32'h00);
        chk("resp_select", 32'(select), 32'd0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_rvalid", 32'(result_valid), 32'd0);
        chk("done_result_held", 32'(result), 32'(e_res));
    endtask

    // Lightweight command used for the wrap test, with a bounded wait.
    task automatic quick_cmd();
        int n;
        in_valid = 1'b1;
        op       = 3'd0;
        pair     = 2'd0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 10) begin
            tick();
            n++;
        end
        if (!result_valid) chk("quick_timeout", 32'(result_valid), 32'd1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        op           = 3'd0;
        pair         = 2'd0;
        result_ready = 1'b0;
        exp_cnt      = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // All opcodes and all operand pairs.
        run_cmd(3'd0, 2'd0, 8'h01, 3'b110, 8'h12);
        run_cmd(3'd4, 2'd1, 8'h10, 3'b101, 8'hF0);
        run_cmd(3'd7, 2'd2, 8'h80, 3'b011, 8'hF6);
        run_cmd(3'd2, 2'd3, 8'h04, 3'b000, 8'h00);
        run_cmd(3'd1, 2'd0, 8'h02, 3'b110, 8'h0B);
        run_cmd(3'd3, 2'd2, 8'h08, 3'b011, 8'hF3);
        run_cmd(3'd5, 2'd3, 8'h20, 3'b000, 8'h0F);
        run_cmd(3'd6, 2'd1, 8'h40, 3'b101, 8'h77);

        // Backpressure: result held, in_valid pulses ignored.
        in_valid = 1'b1;
        op       = 3'd3;
        pair     = 2'd0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        exp_cnt = exp_cnt + 8'd1;
        held    = result;
        chk("bp_result", 32'(held), 32'h0F);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            op       = 3'd7;
            tick();
            chk("bp_rvalid", 32'(result_valid), 32'd1);
            chk("bp_result_stable", 32'(result), 32'(held));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_op_count", 32'(op_count), 32'(exp_cnt));
        end
        in_valid     = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("bp_done_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_no_queued_cmd", 32'(in_ready), 32'd1);
        chk("bp_no_queued_instr", 32'(instruction), 32'h00);

        // Reset and in_valid in the same cycle: reset wins.
        rst      = 1'b1;
        in_valid = 1'b1;
        op       = 3'd5;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("rst_vs_valid");
        tick();
        chk("rst_vs_valid_idle", 32'(instruction), 32'h00);

        // Reset during the second ISSUE cycle.
        exp_cnt  = 8'd0;
        in_valid = 1'b1;
        op       = 3'd4;
        pair     = 2'd1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_issue_instr", 32'(instruction), 32'h10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("mid_issue_rst");
        run_cmd(3'd0, 2'd0, 8'h01, 3'b110, 8'h12);
        chk("after_rst_op_count", 32'(op_count), 32'd1);

        // op_count wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) quick_cmd();
        chk("wrap_256", 32'(op_count), 32'h00);
        quick_cmd();
        chk("wrap_257", 32'(op_count), 32'h01);
        chk("wrap_result", 32'(result), 32'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
